// File: rtl/altera_tse_xcvr_status_responder.sv
`default_nettype none
// ============================================================================
// Module   : altera_tse_xcvr_status_responder
// Function : Behavioural transceiver status model: TX PLL lock, RX offset
//            cancellation and CDR lock, PCS ready flags and reset-order errors.
// Revision : 1.0
// ============================================================================
module altera_tse_xcvr_status_responder #(
    parameter int PLL_LOCK_CYCLES = 20,
    parameter int OC_BUSY_CYCLES  = 8,
    parameter int CDR_LOCK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_powerdown,
    input  logic       tx_digitalreset,
    input  logic       rx_analogreset,
    input  logic       rx_digitalreset,
    input  logic       gxb_powerdown,
    input  logic       rx_signal_present,
    input  logic       force_cdr_unlock,
    input  logic       clear_errors,
    output logic       pll_is_locked,
    output logic       rx_oc_busy,
    output logic       rx_is_lockedtodata,
    output logic       tx_pcs_ready,
    output logic       rx_pcs_ready,
    output logic [2:0] seq_error
);

    // A zero-length window behaves as a single clock.
    localparam int c_PLL_N  = (PLL_LOCK_CYCLES < 1) ? 1 : PLL_LOCK_CYCLES;
    localparam int c_OC_N   = (OC_BUSY_CYCLES  < 1) ? 1 : OC_BUSY_CYCLES;
    localparam int c_CDR_N  = (CDR_LOCK_CYCLES < 1) ? 1 : CDR_LOCK_CYCLES;
    localparam int c_RX_MAX = (c_OC_N > c_CDR_N) ? c_OC_N : c_CDR_N;
    localparam int c_PLL_W  = $clog2(c_PLL_N + 1);
    localparam int c_RX_W   = $clog2(c_RX_MAX + 1);

    localparam logic [c_PLL_W-1:0] c_PLL_LAST = c_PLL_W'(c_PLL_N - 1);
    localparam logic [c_RX_W-1:0]  c_OC_LAST  = c_RX_W'(c_OC_N - 1);
    localparam logic [c_RX_W-1:0]  c_CDR_LAST = c_RX_W'(c_CDR_N - 1);
    localparam logic [c_PLL_W-1:0] c_PLL_ONE  = c_PLL_W'(1);
    localparam logic [c_RX_W-1:0]  c_RX_ONE   = c_RX_W'(1);

    typedef enum logic [1:0] {
        PLL_OFF     = 2'd0,
        PLL_LOCKING = 2'd1,
        PLL_LOCKED  = 2'd2
    } pll_state_t;

    typedef enum logic [2:0] {
        RX_OFF        = 3'd0,
        RX_OC         = 3'd1,
        RX_ANALOG_RST = 3'd2,
        RX_LTR        = 3'd3,
        RX_LTD        = 3'd4
    } rx_state_t;

    pll_state_t          r_pll_state, w_pll_state_nxt;
    logic [c_PLL_W-1:0]  r_pll_cnt,   w_pll_cnt_nxt;
    rx_state_t           r_rx_state,  w_rx_state_nxt;
    logic [c_RX_W-1:0]   r_rx_cnt,    w_rx_cnt_nxt;

    logic       r_tx_pcs_ready;
    logic       r_rx_pcs_ready;
    logic [2:0] r_seq_error;
    logic       r_tx_dr_prev;
    logic       r_rx_dr_prev;
    logic       r_armed;

    logic       w_pll_locked;
    logic       w_rx_ltd;
    logic       w_edge_ok;
    logic       w_tx_fall;
    logic       w_rx_fall;
    logic [2:0] w_err_set;

    assign w_pll_locked = (r_pll_state == PLL_LOCKED);
    assign w_rx_ltd     = (r_rx_state  == RX_LTD);

    always_comb begin
        w_pll_state_nxt = r_pll_state;
        w_pll_cnt_nxt   = r_pll_cnt;
        if (pll_powerdown || gxb_powerdown) begin
            w_pll_state_nxt = PLL_OFF;
            w_pll_cnt_nxt   = '0;
        end else begin
            case (r_pll_state)
                PLL_OFF: begin
                    w_pll_state_nxt = PLL_LOCKING;
                    w_pll_cnt_nxt   = '0;
                end
                PLL_LOCKING: begin
                    if (r_pll_cnt == c_PLL_LAST) begin
                        w_pll_state_nxt = PLL_LOCKED;
                        w_pll_cnt_nxt   = '0;
                    end else begin
                        w_pll_cnt_nxt = r_pll_cnt + c_PLL_ONE;
                    end
                end
                PLL_LOCKED: w_pll_state_nxt = PLL_LOCKED;
                default: begin
                    w_pll_state_nxt = PLL_OFF;
                    w_pll_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        if (gxb_powerdown) begin
            w_rx_state_nxt = RX_OFF;
            w_rx_cnt_nxt   = '0;
        end else begin
            case (r_rx_state)
                RX_OFF: begin
                    w_rx_state_nxt = RX_OC;
                    w_rx_cnt_nxt   = '0;
                end
                // The OC window always runs to completion, analog reset or not.
                RX_OC: begin
                    if (r_rx_cnt == c_OC_LAST) begin
                        w_rx_state_nxt = rx_analogreset ? RX_ANALOG_RST : RX_LTR;
                        w_rx_cnt_nxt   = '0;
                    end else begin
                        w_rx_cnt_nxt = r_rx_cnt + c_RX_ONE;
                    end
                end
                RX_ANALOG_RST: begin
                    if (!rx_analogreset) begin
                        w_rx_state_nxt = RX_LTR;
                        w_rx_cnt_nxt   = '0;
                    end
                end
                RX_LTR: begin
                    if (rx_analogreset) begin
                        w_rx_state_nxt = RX_ANALOG_RST;
                        w_rx_cnt_nxt   = '0;
                    end else if (!(rx_signal_present && w_pll_locked)) begin
                        w_rx_cnt_nxt = '0;
                    end else if (r_rx_cnt == c_CDR_LAST) begin
                        w_rx_state_nxt = RX_LTD;
                        w_rx_cnt_nxt   = '0;
                    end else begin
                        w_rx_cnt_nxt = r_rx_cnt + c_RX_ONE;
                    end
                end
                RX_LTD: begin
                    if (rx_analogreset) begin
                        w_rx_state_nxt = RX_ANALOG_RST;
                        w_rx_cnt_nxt   = '0;
                    end else if (!rx_signal_present || force_cdr_unlock || !w_pll_locked) begin
                        w_rx_state_nxt = RX_LTR;
                        w_rx_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_rx_state_nxt = RX_OFF;
                    w_rx_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pll_state <= PLL_OFF;
            r_pll_cnt   <= '0;
            r_rx_state  <= RX_OFF;
            r_rx_cnt    <= '0;
        end else begin
            r_pll_state <= w_pll_state_nxt;
            r_pll_cnt   <= w_pll_cnt_nxt;
            r_rx_state  <= w_rx_state_nxt;
            r_rx_cnt    <= w_rx_cnt_nxt;
        end
    end

    // Falling edges are ignored on the first clock after reset and during powerdown.
    assign w_edge_ok = r_armed && !gxb_powerdown;
    assign w_tx_fall = w_edge_ok && r_tx_dr_prev && !tx_digitalreset;
    assign w_rx_fall = w_edge_ok && r_rx_dr_prev && !rx_digitalreset;
    assign w_err_set = {w_rx_fall && !w_rx_ltd,
                        w_rx_fall && rx_analogreset,
                        w_tx_fall && !w_pll_locked};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_pcs_ready <= 1'b0;
            r_rx_pcs_ready <= 1'b0;
            r_seq_error    <= 3'b000;
            r_tx_dr_prev   <= 1'b1;
            r_rx_dr_prev   <= 1'b1;
            r_armed        <= 1'b0;
        end else begin
            r_tx_pcs_ready <= !gxb_powerdown && w_pll_locked && !tx_digitalreset;
            r_rx_pcs_ready <= !gxb_powerdown && w_rx_ltd && !rx_digitalreset;
            r_seq_error    <= (clear_errors ? 3'b000 : r_seq_error) | w_err_set;
            r_tx_dr_prev   <= tx_digitalreset;
            r_rx_dr_prev   <= rx_digitalreset;
            r_armed        <= 1'b1;
        end
    end

    assign pll_is_locked      = w_pll_locked;
    assign rx_oc_busy         = (r_rx_state == RX_OC);
    assign rx_is_lockedtodata = w_rx_ltd;
    assign tx_pcs_ready       = r_tx_pcs_ready;
    assign rx_pcs_ready       = r_rx_pcs_ready;
    assign seq_error          = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_altera_tse_xcvr_status_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_altera_tse_xcvr_status_responder
// Function : Checkpoint table plus scoreboard bench for the status responder.
// Revision : 1.0
// ============================================================================
module tb_altera_tse_xcvr_status_responder;

    logic       clock;
    logic       reset_n;
    logic       pll_powerdown;
    logic       tx_digitalreset;
    logic       rx_analogreset;
    logic       rx_digitalreset;
    logic       gxb_powerdown;
    logic       rx_signal_present;
    logic       force_cdr_unlock;
    logic       clear_errors;
    logic       pll_is_locked;
    logic       rx_oc_busy;
    logic       rx_is_lockedtodata;
    logic       tx_pcs_ready;
    logic       rx_pcs_ready;
    logic [2:0] seq_error;

    altera_tse_xcvr_status_responder dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .pll_powerdown      (pll_powerdown),
        .tx_digitalreset    (tx_digitalreset),
        .rx_analogreset     (rx_analogreset),
        .rx_digitalreset    (rx_digitalreset),
        .gxb_powerdown      (gxb_powerdown),
        .rx_signal_present  (rx_signal_present),
        .force_cdr_unlock   (force_cdr_unlock),
        .clear_errors       (clear_errors),
        .pll_is_locked      (pll_is_locked),
        .rx_oc_busy         (rx_oc_busy),
        .rx_is_lockedtodata (rx_is_lockedtodata),
        .tx_pcs_ready       (tx_pcs_ready),
        .rx_pcs_ready       (rx_pcs_ready),
        .seq_error          (seq_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed vector: {seq_error[2:0], rx_pcs_ready, tx_pcs_ready, lockedtodata, oc_busy, pll_locked}
    typedef struct {
        int         test;
        int         edge_n;
        logic [7:0] exp;
        logic [7:0] mask;
    } chk_t;

    chk_t tbl[$];
    chk_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [7:0] obs();
        return {seq_error, rx_pcs_ready, tx_pcs_ready, rx_is_lockedtodata, rx_oc_busy, pll_is_locked};
    endfunction

    // Inputs sampled at edge e of test t:
    // {clear, force, sig_present, gxb, rx_dr, rx_ar, tx_dr, pll_pd}
    function automatic logic [7:0] stim(input int t, input int e);
        logic clr, frc, sig, gxb, rdr, rar, tdr, ppd;
        clr = 0; frc = 0; sig = 1; gxb = 0; rdr = 1; rar = 1; tdr = 1; ppd = 0;
        if (t == 0) begin
            gxb = (e >= 90 && e <= 92);
            tdr = (e < 22);
            rar = (e < 30);
            rdr = (e < 51);
            frc = (e == 60);
            sig = (e < 132);
        end else if (t == 1) begin
            gxb = (e == 20 || e == 21);
            rar = (e < 23);
            tdr = (e < 5) || (e >= 18 && e < 21);
            rdr = (e < 12) || (e >= 14 && e < 16) || (e >= 23 && e < 25);
            clr = (e == 10 || e == 16 || e == 17);
        end else begin
            tdr = 0;
            rdr = 0;
            ppd = (e < 3) || (e == 10);
        end
        return {clr, frc, sig, gxb, rdr, rar, tdr, ppd};
    endfunction

    task automatic apply(input logic [7:0] v);
        {clear_errors, force_cdr_unlock, rx_signal_present, gxb_powerdown,
         rx_digitalreset, rx_analogreset, tx_digitalreset, pll_powerdown} = v;
    endtask

    task automatic compare(input string name, input logic [7:0] got,
                           input logic [7:0] exp, input logic [7:0] mask);
        n_cmp++;
        if ((got & mask) !== (exp & mask)) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (mask %b)", name, got & mask, exp & mask, mask);
        end
    endtask

    task automatic add(input int t, input int e, input logic [7:0] exp, input logic [7:0] mask);
        chk_t c;
        c.test = t; c.edge_n = e; c.exp = exp; c.mask = mask;
        tbl.push_back(c);
    endtask

    task automatic run_test(input int t, input int n_edges);
        chk_t c;
        reset_n = 1'b0;
        apply(stim(t, 0));
        repeat (2) @(posedge clock);
        #1;
        compare($sformatf("t%0d_reset", t), obs(), 8'h00, 8'hFF);
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 0; e < n_edges; e++) begin
            apply(stim(t, e));
            foreach (tbl[i])
                if (tbl[i].test == t && tbl[i].edge_n == e)
                    sb.push_back(tbl[i]);
            @(posedge clock);
            #1;
            while (sb.size() > 0) begin
                c = sb.pop_front();
                compare($sformatf("t%0d_e%0d", t, c.edge_n), obs(), c.exp, c.mask);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        apply(8'h00);

        // Test 0: full bring-up, CDR unlock, powerdown, signal loss
        add(0,   0, 8'b000_00010, 8'hFF);
        add(0,   7, 8'b000_00010, 8'hFF);
        add(0,   8, 8'b000_00000, 8'hFF);
        add(0,  19, 8'b000_00000, 8'hFF);
        add(0,  20, 8'b000_00001, 8'hFF);
        add(0,  22, 8'b000_01001, 8'hFF);
        add(0,  45, 8'b000_01001, 8'hFF);
        add(0,  46, 8'b000_01101, 8'hFF);
        add(0,  50, 8'b000_01101, 8'hFF);
        add(0,  51, 8'b000_11101, 8'hFF);
        add(0,  60, 8'b000_11001, 8'hFF);
        add(0,  61, 8'b000_01001, 8'hFF);
        add(0,  75, 8'b000_01001, 8'hFF);
        add(0,  76, 8'b000_01101, 8'hFF);
        add(0,  77, 8'b000_11101, 8'hFF);
        add(0,  90, 8'b000_00000, 8'hFF);
        add(0,  92, 8'b000_00000, 8'hFF);
        add(0,  93, 8'b000_00010, 8'hFF);
        add(0, 100, 8'b000_00010, 8'hFF);
        add(0, 101, 8'b000_00000, 8'hFF);
        add(0, 113, 8'b000_00001, 8'hFF);
        add(0, 114, 8'b000_01001, 8'hFF);
        add(0, 128, 8'b000_01001, 8'hFF);
        add(0, 129, 8'b000_01101, 8'hFF);
        add(0, 130, 8'b000_11101, 8'hFF);
        add(0, 132, 8'b000_11001, 8'hFF);
        add(0, 135, 8'b000_01001, 8'hFF);
        // Test 1: reset-ordering error flags
        add(1,   0, 8'b000_00000, 8'hE0);
        add(1,   4, 8'b000_00000, 8'hE0);
        add(1,   5, 8'b001_00000, 8'hE0);
        add(1,   9, 8'b001_00000, 8'hE0);
        add(1,  10, 8'b000_00000, 8'hE0);
        add(1,  12, 8'b110_00000, 8'hE0);
        add(1,  15, 8'b110_00000, 8'hE0);
        add(1,  16, 8'b110_00000, 8'hE0);
        add(1,  17, 8'b000_00000, 8'hE0);
        add(1,  21, 8'b000_00000, 8'hE0);
        add(1,  24, 8'b000_00000, 8'hE0);
        add(1,  25, 8'b100_00000, 8'hE0);
        // Test 2: first-clock edge suppression and PLL lock restart
        add(2,   0, 8'b000_00000, 8'hE1);
        add(2,   9, 8'b000_00000, 8'hE1);
        add(2,  23, 8'b000_00000, 8'hE1);
        add(2,  30, 8'b000_00000, 8'hE1);
        add(2,  31, 8'b000_00001, 8'hE1);

        run_test(0, 136);
        // Asynchronous abort while in lock-to-reference, away from any edge
        #1;
        reset_n = 1'b0;
        #1;
        compare("async_reset_mid_ltr", obs(), 8'h00, 8'hFF);

        run_test(1, 27);
        run_test(2, 33);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
